// File: rtl/yuv_stream_packer_pkg.sv
// Shared ISP definitions: bus width, byte-valid encodings and the packed word
// format carried through the output FIFO.
package isp_pkg;

  localparam int YUV_BUS_BYTES = 8;

  localparam logic [7:0] BV_NONE = 8'h00;
  localparam logic [7:0] BV_1PPC = 8'h03;
  localparam logic [7:0] BV_2PPC = 8'h0F;
  localparam logic [7:0] BV_4PPC = 8'hFF;

  typedef struct packed {
    logic [YUV_BUS_BYTES*8-1:0] data;
    logic [YUV_BUS_BYTES-1:0]   keep;
    logic                       last;
  } yuv_word_t;

endpackage

// File: rtl/yuv_stream_packer_if.sv
// Valid/ready output stream of the packer: one 64-bit word per beat.
interface yuv_stream_packer_if;
  import isp_pkg::*;

  logic [YUV_BUS_BYTES*8-1:0] tdata;
  logic [YUV_BUS_BYTES-1:0]   tkeep;
  logic                       tlast;
  logic                       tvalid;
  logic                       tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);

endinterface

// File: rtl/yuv_stream_packer_fifo.sv
// Synchronous show-ahead FIFO of packed words; the head entry is visible
// combinationally and the occupancy count drives the upstream stall.
module yuv_sync_fifo
  import isp_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic      pixel_clk_i,
  input  logic      reset_n_i,
  input  logic      i_push,
  input  yuv_word_t i_pushWord,
  input  logic      i_pop,
  output yuv_word_t o_headWord,
  output logic [AW:0] o_count
);

  localparam logic [AW:0] COUNT_ONE = 1;

  yuv_word_t     r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_count;

  always_ff @(posedge pixel_clk_i) begin
    if (i_push) r_mem[r_wrPtr] <= i_pushWord;
  end

  always_ff @(posedge pixel_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wrPtr <= r_wrPtr + AW'(1);
      if (i_pop)  r_rdPtr <= r_rdPtr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + COUNT_ONE;
        2'b01:   r_count <= r_count - COUNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_headWord = r_mem[r_rdPtr];
  assign o_count    = r_count;

endmodule

// File: rtl/yuv_stream_packer.sv
// Packs 2/4/8-byte YUYV beats into full 64-bit words with end-of-line flush,
// buffers them in a small FIFO and stalls the upstream pipeline when nearly full.
module yuv_stream_packer
  import isp_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       pixel_clk_i,
  input  logic                       reset_n_i,
  input  logic                       line_valid_i,
  input  logic [YUV_BUS_BYTES*8-1:0] yuv_data_i,
  input  logic [YUV_BUS_BYTES-1:0]   yuv_byte_valid_i,
  output logic                       stream_stall_o,
  output logic                       err_o,
  yuv_stream_packer_if.master        m_axis
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] STALL_LEVEL = CW'(FIFO_DEPTH - 1);

  logic [63:0] r_accData;
  logic [3:0]  r_fill;
  logic [63:0] r_pendData;
  logic        r_pendValid;
  logic        r_lineValidQ;
  logic        r_err;

  logic [3:0]  w_beatBytes;
  logic        w_bvLegal;
  logic [63:0] w_byteMask;
  logic [4:0]  w_newFill;
  logic        w_overflow;
  logic        w_accept;
  logic        w_beatOk;
  logic        w_beatErr;
  logic        w_lineEnd;
  logic [63:0] w_merged;
  logic [7:0]  w_partialKeep;
  logic        w_push;
  yuv_word_t   w_pushWord;
  logic        w_pop;
  yuv_word_t   w_head;
  logic [CW-1:0] w_count;
  logic        w_tvalid;

  always_comb begin
    w_beatBytes = 4'd0;
    w_bvLegal   = 1'b1;
    case (yuv_byte_valid_i)
      BV_NONE: w_beatBytes = 4'd0;
      BV_1PPC: w_beatBytes = 4'd2;
      BV_2PPC: w_beatBytes = 4'd4;
      BV_4PPC: w_beatBytes = 4'd8;
      default: w_bvLegal   = 1'b0;
    endcase
  end

  always_comb begin
    w_byteMask = '0;
    for (int i = 0; i < YUV_BUS_BYTES; i++) begin
      w_byteMask[8*i +: 8] = {8{yuv_byte_valid_i[i]}};
    end
  end

  always_comb begin
    case (r_fill)
      4'd2:    w_partialKeep = 8'h03;
      4'd4:    w_partialKeep = 8'h0F;
      4'd6:    w_partialKeep = 8'h3F;
      default: w_partialKeep = 8'h00;
    endcase
  end

  assign w_accept   = line_valid_i && !stream_stall_o;
  assign w_newFill  = {1'b0, r_fill} + {1'b0, w_beatBytes};
  assign w_overflow = w_newFill > 5'd8;
  assign w_beatOk   = w_accept && w_bvLegal && !w_overflow && (w_beatBytes != 4'd0);
  assign w_beatErr  = w_accept && (!w_bvLegal || w_overflow);
  assign w_lineEnd  = r_lineValidQ && !line_valid_i && !stream_stall_o;
  assign w_merged   = r_accData | ((yuv_data_i & w_byteMask) << {r_fill, 3'b000});

  // Pending and a non-zero fill never meet at a line end, so one push per cycle suffices.
  always_comb begin
    w_push     = 1'b0;
    w_pushWord = '0;
    if (w_beatOk && r_pendValid) begin
      w_push     = 1'b1;
      w_pushWord = '{data: r_pendData, keep: 8'hFF, last: 1'b0};
    end else if (w_lineEnd && r_pendValid) begin
      w_push     = 1'b1;
      w_pushWord = '{data: r_pendData, keep: 8'hFF, last: 1'b1};
    end else if (w_lineEnd && (r_fill != 4'd0)) begin
      w_push     = 1'b1;
      w_pushWord = '{data: r_accData, keep: w_partialKeep, last: 1'b1};
    end
  end

  always_ff @(posedge pixel_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_accData    <= '0;
      r_fill       <= '0;
      r_pendData   <= '0;
      r_pendValid  <= 1'b0;
      r_lineValidQ <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (w_beatErr) r_err <= 1'b1;
      if (!stream_stall_o) r_lineValidQ <= line_valid_i;
      if (w_beatOk) begin
        if (w_newFill == 5'd8) begin
          r_pendData  <= w_merged;
          r_pendValid <= 1'b1;
          r_accData   <= '0;
          r_fill      <= '0;
        end else begin
          r_accData   <= w_merged;
          r_fill      <= w_newFill[3:0];
          r_pendValid <= 1'b0;
        end
      end else if (w_lineEnd) begin
        r_pendValid <= 1'b0;
        r_accData   <= '0;
        r_fill      <= '0;
      end
    end
  end

  yuv_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .pixel_clk_i (pixel_clk_i),
    .reset_n_i   (reset_n_i),
    .i_push      (w_push),
    .i_pushWord  (w_pushWord),
    .i_pop       (w_pop),
    .o_headWord  (w_head),
    .o_count     (w_count)
  );

  assign w_tvalid       = w_count != '0;
  assign w_pop          = w_tvalid && m_axis.tready;
  assign stream_stall_o = w_count >= STALL_LEVEL;
  assign err_o          = r_err;

  // Head is gated so the stream reads all-zero while the FIFO is empty.
  assign m_axis.tvalid = w_tvalid;
  assign m_axis.tdata  = w_tvalid ? w_head.data : '0;
  assign m_axis.tkeep  = w_tvalid ? w_head.keep : '0;
  assign m_axis.tlast  = w_tvalid ? w_head.last : 1'b0;

endmodule
